// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-channel registered stream mux with fixed-select or round-robin arbitration
module stream_mux_rr #(
  parameter int N = 4,
  parameter int W = 8,
  localparam int SW = (N > 2) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [N*W-1:0]  in_data,
  input  logic [N-1:0]    in_valid,
  output logic [N-1:0]    in_ready,
  output logic [W-1:0]    out_data,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  input  logic            out_ready
);
  logic [W-1:0] ch [N];
  logic [N-1:0] grant;
  logic [SW-1:0] gidx, idx, ptr, nxt;
  logic load_en, xfer;
  for (genvar i = 0; i < N; i++) begin : g_ch
    assign ch[i] = in_data[i*W +: W];
  end
  assign load_en = !out_valid || out_ready;
  assign in_ready = grant & {N{load_en & rst_n}};
  assign xfer = |in_ready;
  assign nxt = (gidx == SW'(N-1)) ? '0 : gidx + 1'b1;
  always_comb begin
    grant = '0;
    gidx = sel;
    idx = ptr;
    if (!mode) begin
      if ({1'b0, sel} < (SW+1)'(N) && in_valid[sel]) grant[sel] = 1'b1;
    end else begin
      for (int k = 0; k < N; k++) begin
        if (grant == '0 && in_valid[idx]) begin
          grant[idx] = 1'b1;
          gidx = idx;
        end
        idx = (idx == SW'(N-1)) ? '0 : idx + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data <= '0;
      out_ch <= '0;
      ptr <= '0;
    end else begin
      out_valid <= xfer || (out_valid && !out_ready);
      if (xfer) begin
        out_data <= ch[gidx];
        out_ch <= gidx;
        if (mode) ptr <= nxt;
      end
    end
  end
endmodule
